vector_shift_sequencer: RTL and testbench

Sequential issue/writeback front end for the combinational `vector_shift_unit`. It accepts one vector-vector shift request (vsll/vsrl/vsra at any SEW) over a register group of 1, 2, 4 or 8 registers. For each register in the group it reads vs2/vs1 from the vector register file, drives the shift unit, captures `vd` and writes it back. It sits between the vector dispatch stage and the register file, and completes one register every three cycles.

---
 rtl/dragonfang_pkg.sv | 29 ++
 rtl/vector_exec_pkg.sv | 20 ++
 rtl/vector_shift_sequencer.sv | 140 ++++++++++++++
 tb/tb_vector_shift_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dragonfang_pkg.sv
// Core-wide vector parameters, the shift sequencer state type and the
// register-group legality check.
package dragonfang_pkg;

  localparam int unsigned VLEN      = 64;
  localparam int unsigned NUM_VREGS = 32;
  localparam int unsigned VREG_AW   = $clog2(NUM_VREGS);

  typedef enum logic [2:0] {
    VSS_IDLE,
    VSS_READ,
    VSS_SHIFT,
    VSS_WRITE,
    VSS_ERROR
  } vshift_seq_state_t;

  // A group of 1<<lmul registers must start on a multiple of its size and end
  // inside the register file; NUM_VREGS being a power of two means the end is
  // in range exactly when the carry bit of base+N-1 is clear.
  function automatic logic vgroup_legal(input logic [VREG_AW-1:0] base,
                                        input logic [1:0]         lmul);
    logic [VREG_AW-1:0] span;
    logic [VREG_AW:0]   last;
    span = ~({VREG_AW{1'b1}} << lmul);
    last = {1'b0, base} + {1'b0, span};
    return ((base & span) == '0) && !last[VREG_AW];
  endfunction

endpackage : dragonfang_pkg

// File: rtl/vector_exec_pkg.sv
// Execution-vector encodings shared by the vector dispatch stage and the shift unit.
// Only the vector-vector shift encodings are needed by the shift sequencer.
package vector_exec_pkg;

  typedef enum logic [3:0] {
    vsll_8,
    vsll_16,
    vsll_32,
    vsll_64,
    vsrl_8,
    vsrl_16,
    vsrl_32,
    vsrl_64,
    vsra_8,
    vsra_16,
    vsra_32,
    vsra_64
  } execution_vector_t;

endpackage : vector_exec_pkg

// File: rtl/vector_shift_sequencer.sv
// Issue/writeback sequencer for the combinational vector shift unit: walks a
// register group one register per three cycles (read, shift, write).
module vector_shift_sequencer
  import dragonfang_pkg::*;
  import vector_exec_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_n,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  execution_vector_t        req_execution_vector,
  input  logic [VREG_AW-1:0]       req_vs2_addr,
  input  logic [VREG_AW-1:0]       req_vs1_addr,
  input  logic [VREG_AW-1:0]       req_vd_addr,
  input  logic [1:0]               req_lmul,

  output logic                     rf_rd_en,
  output logic [VREG_AW-1:0]       rf_rd_addr_a,
  output logic [VREG_AW-1:0]       rf_rd_addr_b,
  input  logic [VLEN-1:0]          rf_rd_data_a,
  input  logic [VLEN-1:0]          rf_rd_data_b,

  output logic                     rf_wr_en,
  output logic [VREG_AW-1:0]       rf_wr_addr,
  output logic [VLEN-1:0]          rf_wr_data,

  output execution_vector_t        su_execution_vector,
  output logic [VLEN-1:0]          su_vs2,
  output logic [VLEN-1:0]          su_vs1,
  input  logic [VLEN-1:0]          su_vd,

  output logic                     done,
  output logic                     error
);

  vshift_seq_state_t  state_q;
  vshift_seq_state_t  state_d;
  execution_vector_t  ev_q;
  logic [VREG_AW-1:0] vs2_base_q;
  logic [VREG_AW-1:0] vs1_base_q;
  logic [VREG_AW-1:0] vd_base_q;
  logic [1:0]         lmul_q;
  logic [2:0]         idx_q;
  logic [VLEN-1:0]    result_q;

  logic               accept;
  logic               req_legal;
  logic [2:0]         last_idx;
  logic               beat_last;
  logic [VREG_AW-1:0] idx_ext;

  assign accept    = (state_q == VSS_IDLE) && req_valid;
  assign req_legal = vgroup_legal(req_vs2_addr, req_lmul) &&
                     vgroup_legal(req_vs1_addr, req_lmul) &&
                     vgroup_legal(req_vd_addr,  req_lmul);

  assign last_idx  = ~(3'b111 << lmul_q);
  assign beat_last = (idx_q == last_idx);
  assign idx_ext   = {{(VREG_AW-3){1'b0}}, idx_q};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= VSS_IDLE;
      ev_q       <= vsll_8;
      vs2_base_q <= '0;
      vs1_base_q <= '0;
      vd_base_q  <= '0;
      lmul_q     <= '0;
      idx_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ev_q       <= req_execution_vector;
        vs2_base_q <= req_vs2_addr;
        vs1_base_q <= req_vs1_addr;
        vd_base_q  <= req_vd_addr;
        lmul_q     <= req_lmul;
        idx_q      <= '0;
      end
      if (state_q == VSS_SHIFT) begin
        result_q <= su_vd;
      end
      if (state_q == VSS_WRITE && !beat_last) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rf_rd_en  = 1'b0;
    rf_wr_en  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state_q)
      VSS_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_legal ? VSS_READ : VSS_ERROR;
        end
      end
      VSS_READ: begin
        rf_rd_en = 1'b1;
        state_d  = VSS_SHIFT;
      end
      VSS_SHIFT: begin
        state_d = VSS_WRITE;
      end
      VSS_WRITE: begin
        rf_wr_en = 1'b1;
        if (beat_last) begin
          done    = 1'b1;
          state_d = VSS_IDLE;
        end else begin
          state_d = VSS_READ;
        end
      end
      VSS_ERROR: begin
        error   = 1'b1;
        state_d = VSS_IDLE;
      end
      default: state_d = VSS_IDLE;
    endcase
  end

  // RF-facing addresses and data come only from registered state, so the
  // shift-unit operand passthrough cannot disturb them.
  assign rf_rd_addr_a = vs2_base_q + idx_ext;
  assign rf_rd_addr_b = vs1_base_q + idx_ext;
  assign rf_wr_addr   = vd_base_q + idx_ext;
  assign rf_wr_data   = result_q;

  assign su_execution_vector = ev_q;
  assign su_vs2              = rf_rd_data_a;
  assign su_vs1              = rf_rd_data_b;

endmodule : vector_shift_sequencer

// File: tb/tb_vector_shift_sequencer.sv
// Directed bench for vector_shift_sequencer with a register-file model and a
// behavioural shift-unit model.
module tb_vector_shift_sequencer;
  import dragonfang_pkg::*;
  import vector_exec_pkg::*;

  logic              clock;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  execution_vector_t req_execution_vector;
  logic [4:0]        req_vs2_addr, req_vs1_addr, req_vd_addr;
  logic [1:0]        req_lmul;
  logic              rf_rd_en;
  logic [4:0]        rf_rd_addr_a, rf_rd_addr_b;
  logic [63:0]       rf_rd_data_a, rf_rd_data_b;
  logic              rf_wr_en;
  logic [4:0]        rf_wr_addr;
  logic [63:0]       rf_wr_data;
  execution_vector_t su_execution_vector;
  logic [63:0]       su_vs2, su_vs1, su_vd;
  logic              done, error;

  int unsigned n_cmp;
  int unsigned n_bad;

  logic [63:0] mem [0:31];
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [63:0] ld_data;

  logic        obs_rd_en    [0:31];
  logic [4:0]  obs_rd_addr  [0:31];
  logic        obs_wr_en    [0:31];
  logic [4:0]  obs_wr_addr  [0:31];
  logic [63:0] obs_wr_data  [0:31];
  logic        obs_done     [0:31];
  logic        obs_error    [0:31];
  logic        obs_ready    [0:31];

  vector_shift_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_execution_vector(req_execution_vector),
    .req_vs2_addr(req_vs2_addr), .req_vs1_addr(req_vs1_addr),
    .req_vd_addr(req_vd_addr), .req_lmul(req_lmul),
    .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .su_execution_vector(su_execution_vector), .su_vs2(su_vs2), .su_vs1(su_vs1),
    .su_vd(su_vd), .done(done), .error(error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Register file: registered read, write on strobe, bench preload port.
  always @(posedge clock) begin
    if (rf_rd_en) begin
      rf_rd_data_a <= mem[rf_rd_addr_a];
      rf_rd_data_b <= mem[rf_rd_addr_b];
    end
    if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
    if (ld_en)    mem[ld_addr]    <= ld_data;
  end

  function automatic logic [63:0] shift_model(input execution_vector_t ev,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
    int unsigned kind, sew, amt;
    logic [63:0] mask, ea, r, res;
    logic signed [63:0] s;
    kind = int'(ev) / 4;
    sew  = 8 << (int'(ev) % 4);
    mask = (sew == 64) ? '1 : ((64'd1 << sew) - 64'd1);
    res  = '0;
    for (int unsigned e = 0; e < 64 / sew; e++) begin
      ea  = (a >> (e * sew)) & mask;
      amt = int'((b >> (e * sew)) & 64'(sew - 1));
      if (kind == 0)      r = (ea << amt) & mask;
      else if (kind == 1) r = ea >> amt;
      else begin
        s = $signed(ea << (64 - sew));
        s = s >>> (amt + 64 - sew);
        r = 64'(s) & mask;
      end
      res = res | (r << (e * sew));
    end
    return res;
  endfunction

  assign su_vd = shift_model(su_execution_vector, su_vs2, su_vs1);

  task automatic load(input logic [4:0] a, input logic [63:0] d);
    @(negedge clock);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  // Issues one request and records outputs in cycles T+1..T+ncyc; optionally
  // asserts reset after sampling cycle rst_at and releases it one cycle later.
  task automatic run_req(input execution_vector_t ev, input logic [4:0] a2,
                         input logic [4:0] a1, input logic [4:0] ad,
                         input logic [1:0] lmul, input int unsigned ncyc,
                         input int unsigned rst_at);
    @(negedge clock);
    req_valid = 1'b1; req_execution_vector = ev;
    req_vs2_addr = a2; req_vs1_addr = a1; req_vd_addr = ad; req_lmul = lmul;
    for (int unsigned k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      req_valid      = 1'b0;
      obs_rd_en[k]   = rf_rd_en;
      obs_rd_addr[k] = rf_rd_addr_a;
      obs_wr_en[k]   = rf_wr_en;
      obs_wr_addr[k] = rf_wr_addr;
      obs_wr_data[k] = rf_wr_data;
      obs_done[k]    = done;
      obs_error[k]   = error;
      obs_ready[k]   = req_ready;
      if (rst_at != 0 && k == rst_at)     reset_n = 1'b0;
      if (rst_at != 0 && k == rst_at + 1) reset_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_cmp++; if ({rf_rd_en, rf_wr_en, done, error} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_strobes got %b want 0000", {rf_rd_en, rf_wr_en, done, error}); end
    n_cmp++; if ({rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr} !== 15'd0) begin
      n_bad++; $display("FAIL reset_addr got %h want 0", {rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr}); end
    n_cmp++; if (rf_wr_data !== 64'd0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", rf_wr_data); end
  endtask

  task automatic test_vsll_single();
    load(5'd2, 64'h0000_0000_0000_0001);
    load(5'd3, 64'h0000_0000_0000_003F);
    run_req(vsll_64, 5'd2, 5'd3, 5'd4, 2'd0, 4, 0);
    n_cmp++; if (obs_rd_en[1] !== 1'b1 || obs_rd_addr[1] !== 5'd2) begin
      n_bad++; $display("FAIL single_read got en=%b addr=%0d want en=1 addr=2", obs_rd_en[1], obs_rd_addr[1]); end
    for (int unsigned k = 1; k <= 4; k++) begin
      n_cmp++; if (obs_wr_en[k] !== (k == 3) || obs_done[k] !== (k == 3)) begin
        n_bad++; $display("FAIL single_wr_done c%0d got wr=%b done=%b want %b", k, obs_wr_en[k], obs_done[k], k == 3); end
    end
    n_cmp++; if (obs_wr_addr[3] !== 5'd4 || obs_wr_data[3] !== 64'h8000_0000_0000_0000) begin
      n_bad++; $display("FAIL single_wdata got v%0d=%h want v4=8000000000000000", obs_wr_addr[3], obs_wr_data[3]); end
    n_cmp++; if (obs_ready[3] !== 1'b0 || obs_ready[4] !== 1'b1) begin
      n_bad++; $display("FAIL single_ready got %b%b want 01", obs_ready[3], obs_ready[4]); end
  endtask

  task automatic test_vsra_group();
    for (int unsigned r = 0; r < 4; r++) begin
      load(5'(8 + r), 64'h8080_8080_8080_8080);
      load(5'(12 + r), 64'h0707_0707_0707_0707);
    end
    run_req(vsra_8, 5'd8, 5'd12, 5'd16, 2'd2, 13, 0);
    for (int unsigned k = 1; k <= 13; k++) begin
      n_cmp++; if (obs_rd_en[k] !== (k % 3 == 1 && k <= 10)) begin
        n_bad++; $display("FAIL group_rd_en c%0d got %b", k, obs_rd_en[k]); end
      n_cmp++; if (obs_wr_en[k] !== (k % 3 == 0 && k <= 12) || obs_done[k] !== (k == 12)) begin
        n_bad++; $display("FAIL group_wr_done c%0d got wr=%b done=%b", k, obs_wr_en[k], obs_done[k]); end
      if (k % 3 == 0 && k <= 12) begin
        n_cmp++; if (obs_wr_addr[k] !== 5'(16 + k / 3 - 1) || obs_wr_data[k] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
          n_bad++; $display("FAIL group_write c%0d got v%0d=%h want v%0d=ffffffffffffffff",
                            k, obs_wr_addr[k], obs_wr_data[k], 16 + k / 3 - 1); end
      end
    end
    n_cmp++; if (obs_ready[13] !== 1'b1) begin n_bad++; $display("FAIL group_ready got %b want 1", obs_ready[13]); end
  endtask

  task automatic test_illegal();
    run_req(vsll_8, 5'd3, 5'd4, 5'd6, 2'd1, 3, 0);
    n_cmp++; if (obs_error[1] !== 1'b1 || obs_error[2] !== 1'b0) begin
      n_bad++; $display("FAIL illegal_error got %b%b want 10", obs_error[1], obs_error[2]); end
    n_cmp++; if (obs_ready[1] !== 1'b0 || obs_ready[2] !== 1'b1) begin
      n_bad++; $display("FAIL illegal_ready got %b%b want 01", obs_ready[1], obs_ready[2]); end
    for (int unsigned k = 1; k <= 3; k++) begin
      n_cmp++; if ({obs_rd_en[k], obs_wr_en[k], obs_done[k]} !== 3'b000) begin
        n_bad++; $display("FAIL illegal_quiet c%0d got %b want 000", k, {obs_rd_en[k], obs_wr_en[k], obs_done[k]}); end
    end
  endtask

  task automatic test_last_group();
    logic [15:0] hi [0:7];
    hi = '{16'hF000, 16'h7800, 16'h3C00, 16'h1E00, 16'h0F00, 16'h0780, 16'h03C0, 16'h01E0};
    for (int unsigned r = 0; r < 8; r++) begin
      load(5'(r), 64'hF000_0000_0000_0000);
      load(5'(8 + r), 64'(r));
    end
    run_req(vsrl_64, 5'd0, 5'd8, 5'd24, 2'd3, 25, 0);
    for (int unsigned k = 1; k <= 25; k++) begin
      n_cmp++; if (obs_wr_en[k] !== (k % 3 == 0 && k <= 24) || obs_done[k] !== (k == 24)) begin
        n_bad++; $display("FAIL last_wr_done c%0d got wr=%b done=%b", k, obs_wr_en[k], obs_done[k]); end
      if (k % 3 == 0 && k <= 24) begin
        n_cmp++; if (obs_wr_addr[k] !== 5'(24 + k / 3 - 1) || obs_wr_data[k] !== {hi[k / 3 - 1], 48'h0}) begin
          n_bad++; $display("FAIL last_write c%0d got v%0d=%h want v%0d=%h",
                            k, obs_wr_addr[k], obs_wr_data[k], 24 + k / 3 - 1, {hi[k / 3 - 1], 48'h0}); end
      end
    end
    n_cmp++; if (obs_ready[25] !== 1'b1) begin n_bad++; $display("FAIL last_ready got %b want 1", obs_ready[25]); end
    run_req(vsrl_64, 5'd0, 5'd8, 5'd28, 2'd3, 3, 0);
    n_cmp++; if (obs_error[1] !== 1'b1 || obs_rd_en[1] !== 1'b0 || obs_wr_en[3] !== 1'b0) begin
      n_bad++; $display("FAIL wrap_error got err=%b rd=%b wr=%b want 100", obs_error[1], obs_rd_en[1], obs_wr_en[3]); end
  endtask

  task automatic test_overlap();
    load(5'd8,  64'h8000_4000_2000_1000);
    load(5'd9,  64'hFFFF_0F0F_1234_ABCD);
    load(5'd10, 64'h0001_0002_0003_0004);
    load(5'd11, 64'h000F_0010_0004_0008);
    run_req(vsrl_16, 5'd8, 5'd10, 5'd8, 2'd1, 7, 0);
    n_cmp++; if (obs_done[6] !== 1'b1 || obs_ready[7] !== 1'b1) begin
      n_bad++; $display("FAIL overlap_done got done=%b ready=%b want 11", obs_done[6], obs_ready[7]); end
    n_cmp++; if (mem[8] !== 64'h4000_1000_0400_0100) begin
      n_bad++; $display("FAIL overlap_v8 got %h want 4000100004000100", mem[8]); end
    n_cmp++; if (mem[9] !== 64'h0001_0F0F_0123_00AB) begin
      n_bad++; $display("FAIL overlap_v9 got %h want 00010f0f012300ab", mem[9]); end
  endtask

  task automatic test_reset_mid();
    load(5'd4, 64'h0101_0101_0101_0101);
    for (int unsigned r = 0; r < 4; r++) load(5'(20 + r), 64'hDEAD_BEEF_CAFE_0000 | 64'(r));
    run_req(vsll_8, 5'd0, 5'd4, 5'd20, 2'd2, 7, 5);
    for (int unsigned k = 1; k <= 7; k++) begin
      n_cmp++; if (obs_wr_en[k] !== (k == 3) || obs_done[k] !== 1'b0) begin
        n_bad++; $display("FAIL abort_wr_done c%0d got wr=%b done=%b", k, obs_wr_en[k], obs_done[k]); end
    end
    n_cmp++; if (obs_ready[7] !== 1'b1) begin n_bad++; $display("FAIL abort_ready got %b want 1", obs_ready[7]); end
    n_cmp++; if (mem[20] !== 64'hE000_0000_0000_0000) begin
      n_bad++; $display("FAIL abort_v20 got %h want e000000000000000", mem[20]); end
    for (int unsigned r = 1; r < 4; r++) begin
      n_cmp++; if (mem[20 + r] !== (64'hDEAD_BEEF_CAFE_0000 | 64'(r))) begin
        n_bad++; $display("FAIL abort_untouched v%0d got %h", 20 + r, mem[20 + r]); end
    end
    run_req(vsll_8, 5'd1, 5'd4, 5'd21, 2'd0, 4, 0);
    n_cmp++; if (obs_done[3] !== 1'b1 || obs_wr_addr[3] !== 5'd21 || obs_wr_data[3] !== 64'hE000_0000_0000_0000) begin
      n_bad++; $display("FAIL recover got done=%b v%0d=%h want 1 v21=e000000000000000",
                        obs_done[3], obs_wr_addr[3], obs_wr_data[3]); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; req_valid = 1'b0; req_execution_vector = vsll_8;
    req_vs2_addr = '0; req_vs1_addr = '0; req_vd_addr = '0; req_lmul = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    test_vsll_single();
    test_vsra_group();
    test_illegal();
    test_last_group();
    test_overlap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_vector_shift_sequencer
